// File: rtl/dsp38_mac_sequencer_pkg.sv
// Shared widths, DSP38 feedback encodings and the sequencer state type
// for the DSP38 MAC sequencer.
package dsp38_mac_pkg;

    localparam int A_W = 20;
    localparam int B_W = 18;
    localparam int Z_W = 38;

    localparam logic [2:0] FEEDBACK_CLEAR = 3'd1;
    localparam logic [2:0] FEEDBACK_ACC   = 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        HOLD
    } state_t;

endpackage

// File: rtl/dsp38_mac_sequencer_if.sv
// Operand stream (s_*) and result stream (m_*) handshakes of the MAC sequencer.
// The slave modport is the sequencer's view; master is the producer/consumer view.
interface dsp38_mac_sequencer_if;
    import dsp38_mac_pkg::*;

    logic           s_valid;
    logic           s_ready;
    logic [A_W-1:0] s_a;
    logic [B_W-1:0] s_b;
    logic           s_sub;
    logic           m_valid;
    logic           m_ready;
    logic [Z_W-1:0] m_z;

    modport slave (
        input  s_valid, s_a, s_b, s_sub, m_ready,
        output s_ready, m_valid, m_z
    );

    modport master (
        output s_valid, s_a, s_b, s_sub, m_ready,
        input  s_ready, m_valid, m_z
    );

endinterface

// File: rtl/dsp38_mac_sequencer_result_hold.sv
// Result hold register: captures the accumulator on load and keeps it
// stable with valid high until the consumer takes it.
module dsp38_mac_result_hold
    import dsp38_mac_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [Z_W-1:0] d,
    input  logic           ready,
    output logic           valid,
    output logic [Z_W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dsp38_mac_sequencer.sv
// Drives a DSP38 configured as unsigned MAC: FRAME_LEN terms per frame, drain,
// capture Z, hand the result out. Optional stall counter: DSP_MAC_SEQ_STALL_CNT_EN.
module dsp38_mac_sequencer
    import dsp38_mac_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int DSP_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    dsp38_mac_sequencer_if.slave bus,
    output logic [A_W-1:0]       dsp_a,
    output logic [B_W-1:0]       dsp_b,
    output logic                 dsp_load_acc,
    output logic                 dsp_subtract,
    output logic [2:0]           dsp_feedback,
    input  logic [Z_W-1:0]       dsp_z,
    output logic                 busy
`ifdef DSP_MAC_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    state_t     state;
    logic [7:0] beat_cnt;
    logic [2:0] drain_cnt;
    logic       accept;
    logic       first_beat;
    logic       last_beat;
    logic       capture;

    // s_ready is registered, so accept has no combinational path from s_valid to s_ready.
    assign accept     = bus.s_valid && bus.s_ready;
    assign first_beat = (beat_cnt == 8'd0);
    assign last_beat  = (beat_cnt == 8'(FRAME_LEN - 1));
    assign capture    = (state == DRAIN) && (drain_cnt == 3'(DSP_LAT - 1));

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, exactly like the hardware.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            drain_cnt   <= '0;
            bus.s_ready <= 1'b1;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        busy     <= 1'b1;
                        if (last_beat) begin
                            state       <= DRAIN;
                            drain_cnt   <= '0;
                            bus.s_ready <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DRAIN: begin
                    if (capture) state <= HOLD;
                    else         drain_cnt <= drain_cnt + 3'd1;
                end
                HOLD: begin
                    if (bus.m_valid && bus.m_ready) begin
                        state       <= IDLE;
                        beat_cnt    <= '0;
                        bus.s_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand/control issue to the DSP pins; a bubble holds A/B and stops accumulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dsp_a        <= '0;
            dsp_b        <= '0;
            dsp_load_acc <= 1'b0;
            dsp_subtract <= 1'b0;
            dsp_feedback <= FEEDBACK_ACC;
        end else if (accept) begin
            dsp_a        <= bus.s_a;
            dsp_b        <= bus.s_b;
            dsp_load_acc <= 1'b1;
            dsp_subtract <= bus.s_sub;
            dsp_feedback <= first_beat ? FEEDBACK_CLEAR : FEEDBACK_ACC;
        end else begin
            dsp_load_acc <= 1'b0;
            dsp_feedback <= FEEDBACK_ACC;
        end
    end

`ifdef DSP_MAC_SEQ_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (accept && first_beat) begin
            stall_cnt <= '0;
        end else if (state == ACCUM && !accept && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    dsp38_mac_result_hold u_result_hold (
        .clk   (clk),
        .reset (reset),
        .load  (capture),
        .d     (dsp_z),
        .ready (bus.m_ready),
        .valid (bus.m_valid),
        .q     (bus.m_z)
    );

endmodule

// File: tb/tb_dsp38_mac_sequencer.sv
// Directed bench for dsp38_mac_sequencer with a behavioural DSP38 MAC model
// (input registers on, output register off, unsigned A/B).
module tb_dsp38_mac_sequencer;
    import dsp38_mac_pkg::*;

    localparam int FRAME_LEN = 8;
    localparam int DSP_LAT   = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [A_W-1:0] dsp_a;
    logic [B_W-1:0] dsp_b;
    logic           dsp_load_acc;
    logic           dsp_subtract;
    logic [2:0]     dsp_feedback;
    logic [Z_W-1:0] dsp_z;
    logic           busy;
`ifdef DSP_MAC_SEQ_STALL_CNT_EN
    logic [15:0]    stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    dsp38_mac_sequencer_if bus ();

    dsp38_mac_sequencer #(
        .FRAME_LEN (FRAME_LEN),
        .DSP_LAT   (DSP_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .dsp_a        (dsp_a),
        .dsp_b        (dsp_b),
        .dsp_load_acc (dsp_load_acc),
        .dsp_subtract (dsp_subtract),
        .dsp_feedback (dsp_feedback),
        .dsp_z        (dsp_z),
        .busy         (busy)
`ifdef DSP_MAC_SEQ_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // DSP38 model: pins registered at the input stage, Z is the adder output.
    logic [A_W-1:0] a_r   = '0;
    logic [B_W-1:0] b_r   = '0;
    logic           ld_r  = 1'b0;
    logic           sub_r = 1'b0;
    logic [2:0]     fb_r  = 3'd0;
    logic [Z_W-1:0] acc   = '0;
    logic [Z_W-1:0] prod;
    logic [Z_W-1:0] base;

    always @(posedge clk) begin
        a_r   <= dsp_a;
        b_r   <= dsp_b;
        ld_r  <= dsp_load_acc;
        sub_r <= dsp_subtract;
        fb_r  <= dsp_feedback;
        if (ld_r) acc <= dsp_z;
    end

    always_comb begin
        prod  = {18'd0, a_r} * {20'd0, b_r};
        base  = (fb_r == 3'd1) ? '0 : acc;
        dsp_z = !ld_r ? acc : (sub_r ? base - prod : base + prod);
    end

    // Free-running event counters; frames look at differences.
    int n_load = 0, n_clear = 0, n_low = 0, n_hs = 0;
    always @(negedge clk) begin
        if (dsp_load_acc) n_load++;
        if (dsp_load_acc && dsp_feedback == 3'd1) n_clear++;
        if (!bus.s_ready) n_low++;
        if (bus.m_valid && bus.m_ready) n_hs++;
    end

    logic [A_W-1:0] va [FRAME_LEN];
    logic [B_W-1:0] vb [FRAME_LEN];
    logic           vs [FRAME_LEN];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic fill(input int n_add, input logic [A_W-1:0] a0, input logic [B_W-1:0] b0,
                        input logic [A_W-1:0] a1, input logic [B_W-1:0] b1);
        for (int i = 0; i < FRAME_LEN; i++) begin
            va[i] = (i < n_add) ? a0 : a1;
            vb[i] = (i < n_add) ? b0 : b1;
            vs[i] = (i >= n_add);
        end
    endtask

    task automatic run_frame(input string tag, input int gap, input int stall,
                             input logic [Z_W-1:0] exp);
        int l0, c0, w0, h0, n;
        l0 = n_load; c0 = n_clear; w0 = n_low; h0 = n_hs;
        bus.m_ready = (stall == 0);
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (gap != 0 && i > 0) begin
                bus.s_valid = 1'b0;
                step();
            end
            bus.s_valid = 1'b1;
            bus.s_a     = va[i];
            bus.s_b     = vb[i];
            bus.s_sub   = vs[i];
            step();
        end
        bus.s_valid = 1'b0;
        n = 0;
        while (!bus.m_valid && n < 40) begin
            step();
            n++;
        end
        check({tag, "_no_timeout"}, bus.m_valid, 1'b1);
        check({tag, "_mz"}, bus.m_z, exp);
        for (int k = 0; k < stall; k++) begin
            check({tag, "_stall_mz"}, bus.m_z, exp);
            check({tag, "_stall_sready"}, bus.s_ready, 1'b0);
            step();
        end
        bus.m_ready = 1'b1;
        step();
        check({tag, "_mvalid_clr"}, bus.m_valid, 1'b0);
        check({tag, "_idle"}, {bus.s_ready, busy}, 2'b10);
        check({tag, "_loads"}, n_load - l0, FRAME_LEN);
        check({tag, "_clears"}, n_clear - c0, 1);
        check({tag, "_handshakes"}, n_hs - h0, 1);
        check({tag, "_sready_low"}, n_low - w0, DSP_LAT + 1 + stall);
    endtask

    initial begin
        int h0;
        reset       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_a     = '0;
        bus.s_b     = '0;
        bus.s_sub   = 1'b0;
        bus.m_ready = 1'b1;
        step();
        step();
        check("rst_ctrl", {bus.s_ready, bus.m_valid, busy, dsp_load_acc, dsp_subtract, dsp_feedback},
              8'b1000_0000);
        check("rst_data", {bus.m_z, dsp_a, dsp_b}, 76'd0);
        reset = 1'b1;
        step();

        fill(8, 20'd3, 18'd5, 20'd0, 18'd0);
        run_frame("b2b_add", 0, 0, 38'd120);
        check("dsp_a_hold", {dsp_a, dsp_b}, {20'd3, 18'd5});

        fill(4, 20'd10, 18'd10, 20'd2, 18'd3);
        run_frame("mixed_sub", 0, 0, 38'd376);

        fill(8, 20'd3, 18'd5, 20'd0, 18'd0);
        run_frame("bubbles", 1, 0, 38'd120);
`ifdef DSP_MAC_SEQ_STALL_CNT_EN
        check("bubbles_stall_cnt", stall_cnt, 16'd7);
`endif

        fill(8, 20'd3, 18'd5, 20'd0, 18'd0);
        run_frame("backpressure", 0, 5, 38'd120);
        fill(8, 20'd1, 18'd1, 20'd0, 18'd0);
        run_frame("after_bp", 0, 0, 38'd8);

        fill(8, 20'hFFFFF, 18'h3FFFF, 20'd0, 18'd0);
        run_frame("max_ops", 0, 0, 38'h3F_FF60_0008);

        fill(8, 20'd2, 18'd2, 20'd0, 18'd0);
        h0 = n_hs;
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1'b1;
            bus.s_a     = va[i];
            bus.s_b     = vb[i];
            bus.s_sub   = 1'b0;
            step();
        end
        bus.s_valid = 1'b0;
        check("mid_busy", busy, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_ctrl", {bus.s_ready, bus.m_valid, busy, dsp_load_acc, dsp_feedback}, 7'b1000_000);
        check("mid_rst_data", {dsp_a, dsp_b}, 38'd0);
        step();
        reset = 1'b1;
        repeat (6) step();
        check("mid_rst_no_result", {bus.m_valid, 8'(n_hs - h0)}, 9'd0);
        run_frame("after_rst", 0, 0, 38'd32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
